ila_readout_ctrl: RTL and testbench

// Sequences readout of the captured sample ring buffer (BRAM) into the sample-to-nibble

---
 rtl/ila_readout_ctrl.sv | 159 +++++++++++++++
 tb/tb_ila_readout_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ila_readout_ctrl.sv
// -----------------------------------------------------------------------------
// ila_readout_ctrl
//
// Sequences readout of the ILA capture ring buffer (BRAM) into the
// sample-to-nibble serializer. Starting from a trigger-relative address, it
// walks the ring (wrapping modulo DEPTH), pre-fetches the first sample while
// the serializer is still inactive, then keeps the BRAM address one sample
// ahead of the serializer. Each i_smp_rd pulse retires one sample. A one-cycle
// o_done pulse marks the point where the last sample has been shifted out.
//
// Parameters
//   ADDR_WIDTH   BRAM address width; ring depth DEPTH = 2**ADDR_WIDTH
//   RAM_LATENCY  cycles from o_ram_addr/o_ram_en to valid BRAM data (1..4)
//
// Ports
//   i_clk_ILA       in   ILA clock (single clock domain)
//   i_reset         in   asynchronous, active-low reset
//   i_start         in   1-cycle pulse, begins a readout (IDLE only)
//   i_abort         in   1-cycle pulse, cancels a readout (wins over i_start)
//   i_start_addr    in   address of the oldest sample to read
//   i_num_samples   in   samples to read, 0..DEPTH (larger values clamp)
//   i_smp_rd        in   serializer has just loaded the sample at o_ram_addr
//   o_ram_addr      out  BRAM read address (next sample the serializer loads)
//   o_ram_en        out  BRAM read enable
//   o_read_active   out  serializer enable
//   o_busy          out  high in every state except IDLE
//   o_done          out  1-cycle pulse after the final sample completes
//   o_samples_left  out  samples not yet completed
// -----------------------------------------------------------------------------
module ila_readout_ctrl #(
  parameter int ADDR_WIDTH  = 12,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  i_clk_ILA,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH:0]   i_num_samples,
  input  logic                  i_smp_rd,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_en,
  output logic                  o_read_active,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_samples_left
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_STREAM,
    ST_DONE
  } state_t;

  // DEPTH needs one bit more than an address to be representable.
  localparam logic [ADDR_WIDTH:0] DEPTH         = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_LEFT      = (ADDR_WIDTH+1)'(1);
  // PREFETCH holds for RAM_LATENCY+1 cycles: the counter runs 0..RAM_LATENCY.
  localparam logic [2:0]          PREFETCH_LAST = 3'(RAM_LATENCY);

  state_t                state;
  logic [2:0]            pf_cnt;
  logic [ADDR_WIDTH:0]   num_clamped;

  // NOTE: combinational logic assigns every output on every path (here via a
  // single unconditional expression) so no latch can be inferred.
  always_comb begin
    num_clamped = (i_num_samples > DEPTH) ? DEPTH : i_num_samples;
  end

  // o_ram_addr and o_samples_left are the address / remaining-count registers
  // themselves, so they follow the internal state every cycle. All other
  // outputs are registered alongside the state transition that implies them.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk_ILA or negedge i_reset) begin
    // NOTE: the async reset clears every register, outputs included, so the
    // block is quiescent the instant i_reset falls.
    if (!i_reset) begin
      state          <= ST_IDLE;
      pf_cnt         <= '0;
      o_ram_addr     <= '0;
      o_samples_left <= '0;
      o_ram_en       <= 1'b0;
      o_read_active  <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else if (state != ST_IDLE && i_abort) begin
      // Abort: straight back to IDLE, no done pulse, outputs cleared.
      state          <= ST_IDLE;
      pf_cnt         <= '0;
      o_ram_addr     <= '0;
      o_samples_left <= '0;
      o_ram_en       <= 1'b0;
      o_read_active  <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Abort in the same cycle cancels the start.
          if (i_start && !i_abort) begin
            o_ram_addr     <= i_start_addr;
            o_samples_left <= num_clamped;
            pf_cnt         <= '0;
            o_busy         <= 1'b1;
            if (num_clamped == '0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state    <= ST_PREFETCH;
              o_ram_en <= 1'b1;
            end
          end
        end

        ST_PREFETCH: begin
          // The serializer is inactive and keeps reloading BRAM data, so it
          // ends up holding sample[start] once the read latency has elapsed.
          if (pf_cnt == PREFETCH_LAST) begin
            state         <= ST_STREAM;
            o_ram_addr    <= o_ram_addr + 1'b1;
            o_read_active <= 1'b1;
          end else begin
            pf_cnt <= pf_cnt + 3'd1;
          end
        end

        ST_STREAM: begin
          if (i_smp_rd) begin
            if (o_samples_left > ONE_LEFT) begin
              // Address is ADDR_WIDTH bits wide, so DEPTH-1 wraps to 0.
              o_ram_addr     <= o_ram_addr + 1'b1;
              o_samples_left <= o_samples_left - ONE_LEFT;
            end else begin
              state          <= ST_DONE;
              o_samples_left <= '0;
              o_done         <= 1'b1;
              o_read_active  <= 1'b0;
              o_ram_en       <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ila_readout_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ila_readout_ctrl
//
// Directed and randomized readouts of ila_readout_ctrl. Expected addresses and
// remaining counts come from a simple model: after k accepted samples of a
// readout starting at S with N samples, the address is (S+1+k) mod DEPTH and
// N-k samples remain; the N-th pulse produces the done pulse.
// -----------------------------------------------------------------------------
module tb_ila_readout_ctrl;

  localparam int AW    = 12;
  localparam int LAT   = 1;
  localparam int DEPTH = 1 << AW;

  logic          i_clk_ILA = 1'b0;
  logic          i_reset   = 1'b0;
  logic          i_start   = 1'b0;
  logic          i_abort   = 1'b0;
  logic          i_smp_rd  = 1'b0;
  logic [AW-1:0] i_start_addr  = '0;
  logic [AW:0]   i_num_samples = '0;

  logic [AW-1:0] o_ram_addr;
  logic          o_ram_en;
  logic          o_read_active;
  logic          o_busy;
  logic          o_done;
  logic [AW:0]   o_samples_left;

  int checks = 0;
  int errors = 0;

  // Model of the readout in progress.
  int m_start;
  int m_n;

  ila_readout_ctrl #(
    .ADDR_WIDTH (AW),
    .RAM_LATENCY(LAT)
  ) dut (
    .i_clk_ILA     (i_clk_ILA),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_start_addr  (i_start_addr),
    .i_num_samples (i_num_samples),
    .i_smp_rd      (i_smp_rd),
    .o_ram_addr    (o_ram_addr),
    .o_ram_en      (o_ram_en),
    .o_read_active (o_read_active),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_samples_left(o_samples_left)
  );

  always #5 i_clk_ILA = ~i_clk_ILA;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Serializer pacing contract: pulses at least RAM_LATENCY+2 cycles apart.
  int cyc     = 0;
  int last_rd = -100;
  always @(posedge i_clk_ILA) begin
    cyc++;
    if (i_smp_rd === 1'b1) begin
      check("smp_rd_spacing", 32'(cyc - last_rd >= LAT + 2), 32'd1);
      last_rd = cyc;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk_ILA);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},   o_busy,         0);
    check({tag, "_en"},     o_ram_en,       0);
    check({tag, "_active"}, o_read_active,  0);
    check({tag, "_done"},   o_done,         0);
  endtask

  task automatic check_zero(input string tag);
    check_idle(tag);
    check({tag, "_addr"}, o_ram_addr,     0);
    check({tag, "_left"}, o_samples_left, 0);
  endtask

  // Issue a start and check the prefetch window; ends in the first STREAM cycle.
  task automatic begin_readout(input int start, input int num);
    m_start       = start;
    m_n           = (num > DEPTH) ? DEPTH : num;
    i_start_addr  = start[AW-1:0];
    i_num_samples = num[AW:0];
    i_start       = 1'b1;
    tick();
    i_start       = 1'b0;
    if (m_n == 0) return;
    for (int i = 0; i <= LAT; i++) begin
      check("pf_en",     o_ram_en,       1);
      check("pf_active", o_read_active,  0);
      check("pf_busy",   o_busy,         1);
      check("pf_addr",   o_ram_addr,     32'(start));
      check("pf_left",   o_samples_left, 32'(m_n));
      tick();
    end
    check("stream_addr0",   o_ram_addr,    32'((start + 1) % DEPTH));
    check("stream_active0", o_read_active, 1);
  endtask

  // k = samples already accepted in this readout; pulse arrives gap cycles on.
  task automatic stream_step(input int k, input int gap);
    repeat (gap - 1) tick();
    check("hold_addr", o_ram_addr, 32'((m_start + 1 + k) % DEPTH));
    check("hold_done", o_done,     0);
    i_smp_rd = 1'b1;
    tick();
    i_smp_rd = 1'b0;
    if (k + 1 < m_n) begin
      check("rd_addr",   o_ram_addr,     32'((m_start + 2 + k) % DEPTH));
      check("rd_left",   o_samples_left, 32'(m_n - 1 - k));
      check("rd_active", o_read_active,  1);
    end else begin
      check("last_done",   o_done,         1);
      check("last_left",   o_samples_left, 0);
      check("last_active", o_read_active,  0);
      check("last_en",     o_ram_en,       0);
      check("last_busy",   o_busy,         1);
    end
  endtask

  task automatic finish_readout();
    tick();
    check("post_done", o_done, 0);
    check("post_busy", o_busy, 0);
  endtask

  task automatic run(input int start, input int num, input int gap);
    begin_readout(start, num);
    if (m_n == 0) begin
      check("zero_done",   o_done,         1);
      check("zero_busy",   o_busy,         1);
      check("zero_active", o_read_active,  0);
      check("zero_left",   o_samples_left, 0);
    end else begin
      for (int k = 0; k < m_n; k++) stream_step(k, gap);
    end
    finish_readout();
  endtask

  initial begin
    // Reset held: everything quiet.
    repeat (2) tick();
    check_zero("reset");
    #3 i_reset = 1'b1;
    tick();
    check_zero("after_reset");

    // Basic readout, slow pacing.
    run(10, 3, 20);
    // Wrap-around.
    run(DEPTH - 2, 4, 6);
    // Empty readout.
    run(123, 0, 3);
    // Oversized request clamps to DEPTH.
    run(int'($urandom_range(0, DEPTH - 1)), DEPTH + 5, LAT + 2);

    // Randomized readouts.
    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 12)),
          int'($urandom_range(LAT + 2, LAT + 6)));

    // Abort after the second accepted sample.
    begin_readout(100, 5);
    stream_step(0, 5);
    stream_step(1, 5);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check_zero("abort");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_done", o_done, 0);
    end

    // Abort and start together mid-readout: abort wins.
    begin_readout(200, 4);
    stream_step(0, 4);
    i_abort       = 1'b1;
    i_start       = 1'b1;
    i_start_addr  = 12'd7;
    i_num_samples = 13'd2;
    tick();
    i_abort = 1'b0;
    i_start = 1'b0;
    check_zero("abort_start");
    tick();
    check("abort_start_ignored", o_busy, 0);

    // Abort and start together in IDLE: start ignored.
    i_abort = 1'b1;
    i_start = 1'b1;
    tick();
    i_abort = 1'b0;
    i_start = 1'b0;
    check("idle_abort_start_busy", o_busy, 0);
    tick();
    check("idle_abort_start_busy2", o_busy, 0);
    run(300, 3, 5);

    // Start while busy: not re-latched, the readout continues unchanged.
    begin_readout(40, 4);
    stream_step(0, 5);
    i_start       = 1'b1;
    i_start_addr  = 12'd999;
    i_num_samples = 13'd1;
    tick();
    i_start = 1'b0;
    for (int k = 1; k < 4; k++) stream_step(k, 5);
    finish_readout();

    // Async reset mid-stream: outputs clear before the next edge.
    begin_readout(500, 6);
    stream_step(0, 4);
    stream_step(1, 4);
    #2 i_reset = 1'b0;
    #1;
    check_zero("async_reset");
    tick();
    check_zero("reset_held");
    #3 i_reset = 1'b1;
    tick();
    check_zero("reset_release");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_no_done", o_done, 0);
    end

    // Serializer pulse in IDLE is ignored.
    i_smp_rd = 1'b1;
    tick();
    i_smp_rd = 1'b0;
    check_zero("idle_smp_rd");
    tick();
    check("idle_smp_rd_busy", o_busy, 0);

    // Normal readout afterwards, wrapping at the top.
    run(DEPTH - 1, 2, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
